// File: rtl/sub16_serial.sv
// Bit-serial subtractor: DIFF = OP_A - OP_B - BWI, one bit per clock, LSB first.
// Ports: CLK, RST (async high), START/BWI/OP_A/OP_B in; BUSY, DONE, DIFF, BWO, OVF, N/Z/P out.
module sub16_serial #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             BWI,
  input  logic [WIDTH-1:0] OP_A,
  input  logic [WIDTH-1:0] OP_B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] DIFF,
  output logic             BWO,
  output logic             OVF,
  output logic             N,
  output logic             Z,
  output logic             P
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bw_q, bw_d;
  logic             amsb_q, amsb_d, bmsb_q, bmsb_d;
  logic             bwo_q, bwo_d, ovf_q, ovf_d;
  logic             n_q, n_d, z_q, z_d, p_q, p_d;

  logic             abit, bbit, dbit, bwn;
  logic [WIDTH-1:0] res_sh;

  always_comb begin
    abit   = a_q[0];
    bbit   = b_q[0];
    dbit   = abit ^ bbit ^ bw_q;
    bwn    = (~abit & bbit) | (~(abit ^ bbit) & bw_q);
    res_sh = {dbit, res_q[WIDTH-1:1]};

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    bw_d    = bw_q;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    bwo_d   = bwo_q;
    ovf_d   = ovf_q;
    n_d     = n_q;
    z_d     = z_q;
    p_d     = p_q;

    unique case (state_q)
      IDLE: begin
        if (START) begin
          state_d = RUN;
          a_d     = OP_A;
          b_d     = OP_B;
          bw_d    = BWI;
          // Operand signs kept aside: the shift registers lose them.
          amsb_d  = OP_A[WIDTH-1];
          bmsb_d  = OP_B[WIDTH-1];
          res_d   = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        bw_d  = bwn;
        res_d = res_sh;
        if (cnt_q == LAST) begin
          state_d = FIN;
          cnt_d   = '0;
          // Last bit processed this edge is the result MSB.
          diff_d  = res_sh;
          bwo_d   = bwn;
          ovf_d   = (amsb_q != bmsb_q) && (dbit != amsb_q);
          n_d     = dbit;
          z_d     = (res_sh == '0);
          p_d     = ~dbit & (res_sh != '0);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      bw_q    <= 1'b0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      bwo_q   <= 1'b0;
      ovf_q   <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      p_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      bw_q    <= bw_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      bwo_q   <= bwo_d;
      ovf_q   <= ovf_d;
      n_q     <= n_d;
      z_q     <= z_d;
      p_q     <= p_d;
    end
  end

  assign BUSY = (state_q == RUN);
  assign DONE = (state_q == FIN);
  assign DIFF = diff_q;
  assign BWO  = bwo_q;
  assign OVF  = ovf_q;
  assign N    = n_q;
  assign Z    = z_q;
  assign P    = p_q;

endmodule

// File: tb/tb_sub16_serial.sv
// Scoreboard bench for sub16_serial: stimulus pushes expected results,
// a negedge monitor pops and compares on every DONE pulse.
module tb_sub16_serial;

  logic        CLK, RST, START, BWI;
  logic [15:0] OP_A, OP_B, DIFF;
  logic        BUSY, DONE, BWO, OVF, N, Z, P;

  sub16_serial #(.WIDTH(16)) dut (
    .CLK(CLK), .RST(RST), .START(START), .BWI(BWI),
    .OP_A(OP_A), .OP_B(OP_B), .BUSY(BUSY), .DONE(DONE),
    .DIFF(DIFF), .BWO(BWO), .OVF(OVF), .N(N), .Z(Z), .P(P)
  );

  typedef struct {
    logic [15:0] diff;
    logic        bwo, ovf, n, z, p;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   ndone = 0;
  int   cyc   = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compares every completion against the oldest expectation.
  always @(negedge CLK) begin
    if (!RST && DONE) begin
      exp_t e;
      ndone++;
      chk("busy_with_done", {31'd0, BUSY}, 32'd0);
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_done: got DONE at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        chk("latency", cyc - e.cyc, 32'd16);
        chk("diff", {16'd0, DIFF}, {16'd0, e.diff});
        chk("bwo", {31'd0, BWO}, {31'd0, e.bwo});
        chk("ovf", {31'd0, OVF}, {31'd0, e.ovf});
        chk("n", {31'd0, N}, {31'd0, e.n});
        chk("z", {31'd0, Z}, {31'd0, e.z});
        chk("p", {31'd0, P}, {31'd0, e.p});
      end
    end
  end

  task automatic chk_zero(string nm);
    chk({nm, "_busy"}, {31'd0, BUSY}, 32'd0);
    chk({nm, "_done"}, {31'd0, DONE}, 32'd0);
    chk({nm, "_flags"}, {27'd0, BWO, OVF, N, Z, P}, 32'd0);
    chk({nm, "_diff"}, {16'd0, DIFF}, 32'd0);
  endtask

  // Issue one accepted START; the expected result is queued with its start edge.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                          input logic bi, input logic [15:0] ed,
                          input logic [4:0] fl);
    exp_t e;
    @(negedge CLK);
    OP_A  = a;
    OP_B  = b;
    BWI   = bi;
    START = 1'b1;
    @(posedge CLK);
    #1;
    e.diff = ed;
    e.bwo  = fl[4];
    e.ovf  = fl[3];
    e.n    = fl[2];
    e.z    = fl[1];
    e.p    = fl[0];
    e.cyc  = cyc;
    sb.push_back(e);
    @(negedge CLK);
    START = 1'b0;
    OP_A  = 16'($urandom);
    OP_B  = 16'($urandom);
    BWI   = 1'($urandom);
  endtask

  task automatic wait_done(input int target);
    int k = 0;
    while (ndone < target && k < 80) begin
      @(negedge CLK);
      k++;
    end
    @(negedge CLK);
    if (ndone < target) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got %0d dones expected %0d", ndone, target);
    end
  endtask

  initial begin
    int s;
    int lows;
    exp_t e;
    RST   = 1'b1;
    START = 1'b0;
    BWI   = 1'b0;
    OP_A  = '0;
    OP_B  = '0;
    repeat (3) @(negedge CLK);
    chk_zero("reset");
    RST = 1'b0;
    @(negedge CLK);
    chk_zero("post_reset");

    // flags order: {bwo, ovf, n, z, p}
    start_op(16'h1111, 16'h1111, 1'b0, 16'h0000, 5'b00010);
    wait_done(1);
    start_op(16'h1111, 16'h1234, 1'b1, 16'hFEDC, 5'b10100);
    wait_done(2);
    start_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 5'b01001);
    wait_done(3);
    start_op(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 5'b10100);
    wait_done(4);
    start_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 5'b11100);
    wait_done(5);

    // START pulse mid-run must be ignored.
    start_op(16'h0005, 16'h0003, 1'b0, 16'h0002, 5'b00001);
    repeat (6) @(negedge CLK);
    OP_A  = 16'hFFFF;
    OP_B  = 16'h0001;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_done(6);
    repeat (20) @(negedge CLK);
    chk("single_done", ndone, 32'd6);
    chk("held_diff", {16'd0, DIFF}, 32'h0002);

    // Reset in the middle of an operation aborts it.
    start_op(16'h0005, 16'h0003, 1'b0, 16'h0002, 5'b00001);
    wait_done(7);
    start_op(16'h1111, 16'h1234, 1'b1, 16'hFEDC, 5'b10100);
    repeat (6) @(posedge CLK);
    #2;
    sb.delete();
    RST = 1'b1;
    #1;
    chk_zero("async_reset");
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (20) @(negedge CLK);
    chk("no_done_after_abort", ndone, 32'd7);
    start_op(16'h0003, 16'h0005, 1'b0, 16'hFFFE, 5'b10100);
    wait_done(8);

    // START held high: operations every 18 edges.
    @(negedge CLK);
    OP_A  = 16'h1234;
    OP_B  = 16'h1111;
    BWI   = 1'b0;
    START = 1'b1;
    @(posedge CLK);
    #1;
    s = cyc;
    e.diff = 16'h0123;
    e.bwo  = 1'b0;
    e.ovf  = 1'b0;
    e.n    = 1'b0;
    e.z    = 1'b0;
    e.p    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e.cyc = s + 18 * i;
      sb.push_back(e);
    end
    lows = 0;
    for (int i = 0; i < 36; i++) begin
      @(negedge CLK);
      if (!BUSY) lows++;
    end
    chk("busy_low_cycles", lows, 32'd4);
    repeat (4) @(negedge CLK);
    START = 1'b0;
    wait_done(11);
    repeat (20) @(negedge CLK);
    chk("b2b_done_count", ndone, 32'd11);
    chk("queue_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
